// File: rtl/mul24_arbiter_if.sv
// mul24_arbiter_if: bundles the two request ports, the multiplier issue/return path
// and the two result ports of the shared 24x24 multiplier arbiter.
// slave  = arbiter side, master = requester / multiplier / consumer side.
interface mul24_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [23:0] req0_a;
  logic [23:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [23:0] req1_a;
  logic [23:0] req1_b;
  logic [23:0] mul_a;
  logic [23:0] mul_b;
  logic        mul_issue;
  logic [47:0] mul_p;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic [47:0] rsp0_p;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [47:0] rsp1_p;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  mul_p, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, mul_a, mul_b, mul_issue,
    output rsp0_valid, rsp0_p, rsp1_valid, rsp1_p
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output mul_p, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, mul_a, mul_b, mul_issue,
    input  rsp0_valid, rsp0_p, rsp1_valid, rsp1_p
  );
endinterface

// File: rtl/mul24_arbiter.sv
// mul24_arbiter: two-port arbiter/sequencer in front of a free-running 24x24
// multiplier of fixed latency MUL_LAT. Each issued op carries a port tag down a
// shift register; the returning product lands in that port's result FIFO.
// Per-port credits reserve a FIFO slot at accept time, since the multiplier
// cannot be stalled.
// Build option: define MUL24_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins
// ties, no round-robin pointer); default is round-robin.
module mul24_arbiter #(
  parameter int MUL_LAT    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mul24_arbiter_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int AW = PW + 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(FIFO_DEPTH);

  logic [1:0]         elig, grant, pop, wr, full, empty, rsp_ready;
  logic               accept;
  logic [CW-1:0]      cred_q [2];
  logic [CW-1:0]      cred_d [2];
  logic [23:0]        mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic               mul_issue_q, mul_issue_d;
  logic               issue_port_q, issue_port_d;
  logic [MUL_LAT-1:0] tag_vld_q, tag_vld_d, tag_port_q, tag_port_d;
  logic [AW-1:0]      wptr_q [2];
  logic [AW-1:0]      wptr_d [2];
  logic [AW-1:0]      rptr_q [2];
  logic [AW-1:0]      rptr_d [2];
  logic [47:0]        mem_q [2][FIFO_DEPTH];
  logic [47:0]        mem_d [2][FIFO_DEPTH];
`ifndef MUL24_ARB_FIXED_PRIO_EN
  logic               rr_ptr_q, rr_ptr_d;
`endif

  // Eligibility and grant: a port needs a request and a reserved FIFO slot
  always_comb begin
    elig[0] = bus.req0_valid && (cred_q[0] != '0);
    elig[1] = bus.req1_valid && (cred_q[1] != '0);
    grant   = 2'b00;
`ifdef MUL24_ARB_FIXED_PRIO_EN
    if (elig[0])      grant = 2'b01;
    else if (elig[1]) grant = 2'b10;
`else
    rr_ptr_d = rr_ptr_q;
    if (elig == 2'b11) grant = rr_ptr_q ? 2'b10 : 2'b01;
    else               grant = elig;
    // Pointer moves to the loser, i.e. to port 1 exactly when port 0 won
    if (grant != 2'b00) rr_ptr_d = grant[0];
`endif
    accept = grant[0] | grant[1];
  end

  // Issue register and port-tag shift register tracking the multiplier pipeline
  always_comb begin
    mul_issue_d  = accept;
    issue_port_d = accept ? grant[1] : issue_port_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    if (grant[0]) begin
      mul_a_d = bus.req0_a;
      mul_b_d = bus.req0_b;
    end else if (grant[1]) begin
      mul_a_d = bus.req1_a;
      mul_b_d = bus.req1_b;
    end
    tag_vld_d     = tag_vld_q;
    tag_port_d    = tag_port_q;
    tag_vld_d[0]  = mul_issue_q;
    tag_port_d[0] = issue_port_q;
    for (int i = 1; i < MUL_LAT; i++) begin
      tag_vld_d[i]  = tag_vld_q[i-1];
      tag_port_d[i] = tag_port_q[i-1];
    end
  end

  // Result FIFOs and credit counters; an accept and a pop in one cycle cancel
  always_comb begin
    rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
    for (int p = 0; p < 2; p++) begin
      empty[p]  = (wptr_q[p] == rptr_q[p]);
      full[p]   = (wptr_q[p][PW] != rptr_q[p][PW]) &&
                  (wptr_q[p][PW-1:0] == rptr_q[p][PW-1:0]);
      pop[p]    = !empty[p] && rsp_ready[p];
      wr[p]     = tag_vld_q[MUL_LAT-1] && (tag_port_q[MUL_LAT-1] == 1'(p));
      cred_d[p] = cred_q[p] - CW'(grant[p]) + CW'(pop[p]);
      wptr_d[p] = wptr_q[p] + AW'(wr[p]);
      rptr_d[p] = rptr_q[p] + AW'(pop[p]);
      mem_d[p]  = mem_q[p];
      if (wr[p]) mem_d[p][wptr_q[p][PW-1:0]] = bus.mul_p;
    end
  end

  // Control, issue and tag state; reset drops every in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cred_q[0]    <= CRED_MAX;
      cred_q[1]    <= CRED_MAX;
      wptr_q[0]    <= '0;
      wptr_q[1]    <= '0;
      rptr_q[0]    <= '0;
      rptr_q[1]    <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_issue_q  <= 1'b0;
      issue_port_q <= 1'b0;
      tag_vld_q    <= '0;
      tag_port_q   <= '0;
    end else begin
      cred_q       <= cred_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_issue_q  <= mul_issue_d;
      issue_port_q <= issue_port_d;
      tag_vld_q    <= tag_vld_d;
      tag_port_q   <= tag_port_d;
    end
  end

  // FIFO storage, cleared so an empty FIFO head reads zero after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++)
        for (int e = 0; e < FIFO_DEPTH; e++) mem_q[p][e] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

`ifndef MUL24_ARB_FIXED_PRIO_EN
  // Round-robin tie-break pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= 1'b0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

  // Credits guarantee a returning product never meets a full FIFO
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) (wr & full) == 2'b00);

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.mul_issue  = mul_issue_q;
  assign bus.rsp0_valid = !empty[0];
  assign bus.rsp1_valid = !empty[1];
  assign bus.rsp0_p     = mem_q[0][rptr_q[0][PW-1:0]];
  assign bus.rsp1_p     = mem_q[1][rptr_q[1][PW-1:0]];
endmodule
